// File: rtl/alu_cmd_sequencer.sv
// Command sequencer for the 4-class ALU: accepts a command, pulses ALU_EN once, waits for the result strobe and returns the result.
// Optional WAIT timeout error path is enabled by defining ALU_SEQ_TIMEOUT_EN.
//
// state   | meaning
// --------+------------------------------------------------------
// S_IDLE  | ready for a command (CMD_READY high once out of reset)
// S_ISSUE | ALU_EN pulse, timeout counter cleared
// S_WAIT  | waiting for ALU_OUT_VALID (or timeout when enabled)
// S_DONE  | RES_VALID high, result held until RES_READY
module alu_cmd_sequencer #(
    parameter int DATA_WIDTH = 8,
    parameter int OUT_WIDTH  = 16,
    parameter int TIMEOUT    = 15
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  CMD_VALID,
    output logic                  CMD_READY,
    input  logic [DATA_WIDTH-1:0] CMD_A,
    input  logic [DATA_WIDTH-1:0] CMD_B,
    input  logic [3:0]            CMD_FUN,
    output logic [DATA_WIDTH-1:0] ALU_A,
    output logic [DATA_WIDTH-1:0] ALU_B,
    output logic [3:0]            ALU_FUN,
    output logic                  ALU_EN,
    input  logic [OUT_WIDTH-1:0]  ALU_OUT,
    input  logic                  ALU_OUT_VALID,
    output logic [OUT_WIDTH-1:0]  RES_DATA,
    output logic                  RES_VALID,
    input  logic                  RES_READY,
    output logic                  RES_ERR,
    output logic                  BUSY
);

    if (TIMEOUT < 1 || TIMEOUT > 255) begin : g_bad_timeout
        $error("alu_cmd_sequencer: TIMEOUT must be within 1..255");
    end

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t                  r_state;
    state_t                  w_next_state;
    logic                    r_cmd_ready;
    logic [DATA_WIDTH-1:0]   r_alu_a;
    logic [DATA_WIDTH-1:0]   r_alu_b;
    logic [3:0]              r_alu_fun;
    logic [OUT_WIDTH-1:0]    r_res_data;
    logic                    w_accept;
    logic                    w_strobe;
    logic                    w_timeout;

    assign w_accept = CMD_VALID & r_cmd_ready;
    assign w_strobe = (r_state == S_WAIT) & ALU_OUT_VALID;

`ifdef ALU_SEQ_TIMEOUT_EN
    localparam logic [7:0] LP_TC = 8'(TIMEOUT - 1);

    logic [7:0] r_cnt;
    logic       r_res_err;

    // A strobe in the terminal cycle takes priority over the timeout.
    assign w_timeout = (r_state == S_WAIT) & ~ALU_OUT_VALID & (r_cnt == LP_TC);

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            r_cnt <= 8'd0;
        end else if (r_state == S_ISSUE) begin
            r_cnt <= 8'd0;
        end else if (r_state == S_WAIT && r_cnt != 8'hFF) begin
            r_cnt <= r_cnt + 8'd1;
        end
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            r_res_data <= '0;
            r_res_err  <= 1'b0;
        end else if (w_strobe) begin
            r_res_data <= ALU_OUT;
            r_res_err  <= 1'b0;
        end else if (w_timeout) begin
            r_res_data <= '0;
            r_res_err  <= 1'b1;
        end
    end

    assign RES_ERR = r_res_err;
`else
    assign w_timeout = 1'b0;

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            r_res_data <= '0;
        end else if (w_strobe) begin
            r_res_data <= ALU_OUT;
        end
    end

    assign RES_ERR = 1'b0;
`endif

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE:  if (w_accept) w_next_state = S_ISSUE;
            S_ISSUE: w_next_state = S_WAIT;
            S_WAIT:  if (w_strobe || w_timeout) w_next_state = S_DONE;
            S_DONE:  if (RES_READY) w_next_state = S_IDLE;
            default: w_next_state = S_IDLE;
        endcase
    end

    // CMD_READY is registered from the next state so it stays low during reset.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            r_state     <= S_IDLE;
            r_cmd_ready <= 1'b0;
        end else begin
            r_state     <= w_next_state;
            r_cmd_ready <= (w_next_state == S_IDLE);
        end
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            r_alu_a   <= '0;
            r_alu_b   <= '0;
            r_alu_fun <= 4'd0;
        end else if (w_accept) begin
            r_alu_a   <= CMD_A;
            r_alu_b   <= CMD_B;
            r_alu_fun <= CMD_FUN;
        end
    end

    assign CMD_READY = r_cmd_ready;
    assign ALU_A     = r_alu_a;
    assign ALU_B     = r_alu_b;
    assign ALU_FUN   = r_alu_fun;
    assign ALU_EN    = (r_state == S_ISSUE);
    assign RES_DATA  = r_res_data;
    assign RES_VALID = (r_state == S_DONE);
    assign BUSY      = (r_state != S_IDLE);

endmodule

// File: tb/tb_alu_cmd_sequencer.sv
// Directed bench for alu_cmd_sequencer: stimulus pushes expected results, a monitor pops them on each result handshake.
// Follows the DUT build: timeout checks run when ALU_SEQ_TIMEOUT_EN is defined.
module tb_alu_cmd_sequencer;

    logic        CLK = 1'b0;
    logic        RST = 1'b0;
    logic        CMD_VALID = 1'b0;
    logic        CMD_READY;
    logic [7:0]  CMD_A = 8'd0;
    logic [7:0]  CMD_B = 8'd0;
    logic [3:0]  CMD_FUN = 4'd0;
    logic [7:0]  ALU_A;
    logic [7:0]  ALU_B;
    logic [3:0]  ALU_FUN;
    logic        ALU_EN;
    logic [15:0] ALU_OUT = 16'd0;
    logic        ALU_OUT_VALID = 1'b0;
    logic [15:0] RES_DATA;
    logic        RES_VALID;
    logic        RES_READY = 1'b0;
    logic        RES_ERR;
    logic        BUSY;

    int total = 0;
    int bad   = 0;

    typedef struct packed {
        logic [15:0] data;
        logic        err;
    } exp_t;

    exp_t exp_q[$];

    alu_cmd_sequencer #(.DATA_WIDTH(8), .OUT_WIDTH(16), .TIMEOUT(15)) dut (
        .CLK(CLK), .RST(RST),
        .CMD_VALID(CMD_VALID), .CMD_READY(CMD_READY),
        .CMD_A(CMD_A), .CMD_B(CMD_B), .CMD_FUN(CMD_FUN),
        .ALU_A(ALU_A), .ALU_B(ALU_B), .ALU_FUN(ALU_FUN), .ALU_EN(ALU_EN),
        .ALU_OUT(ALU_OUT), .ALU_OUT_VALID(ALU_OUT_VALID),
        .RES_DATA(RES_DATA), .RES_VALID(RES_VALID), .RES_READY(RES_READY),
        .RES_ERR(RES_ERR), .BUSY(BUSY)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(negedge CLK);
    endtask

    task automatic drive_cmd(input logic [7:0] a, input logic [7:0] b, input logic [3:0] f);
        CMD_VALID = 1'b1;
        CMD_A     = a;
        CMD_B     = b;
        CMD_FUN   = f;
    endtask

    // Handshake is evaluated just before the rising edge that completes it.
    initial begin
        exp_t e;
        forever begin
            @(negedge CLK);
            #2;
            if (RES_VALID && RES_READY) begin
                if (exp_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_result: got data=%0h err=%0b expected none", RES_DATA, RES_ERR);
                end else begin
                    e = exp_q.pop_front();
                    chk("res_data", 32'(RES_DATA), 32'(e.data));
                    chk("res_err",  32'(RES_ERR),  32'(e.err));
                end
            end
        end
    end

    initial begin
        tick();
        chk("rst_cmd_ready", 32'(CMD_READY), 32'd0);
        chk("rst_busy",      32'(BUSY),      32'd0);
        chk("rst_alu_en",    32'(ALU_EN),    32'd0);
        chk("rst_res_valid", 32'(RES_VALID), 32'd0);
        chk("rst_res_err",   32'(RES_ERR),   32'd0);
        chk("rst_alu_ab",    32'({ALU_A, ALU_B, ALU_FUN}), 32'd0);
        chk("rst_res_data",  32'(RES_DATA),  32'd0);
        RST = 1'b1;
        tick();
        chk("post_rst_cmd_ready", 32'(CMD_READY), 32'd1);

        // Single command, strobe at first WAIT cycle, result held with RES_READY low.
        drive_cmd(8'h12, 8'h34, 4'b0000);
        tick();
        CMD_VALID = 1'b0;
        chk("t1_alu_en",     32'(ALU_EN),    32'd1);
        chk("t1_alu_a",      32'(ALU_A),     32'h12);
        chk("t1_alu_b",      32'(ALU_B),     32'h34);
        chk("t1_alu_fun",    32'(ALU_FUN),   32'h0);
        chk("t1_cmd_ready",  32'(CMD_READY), 32'd0);
        tick();
        chk("t1_alu_en_off", 32'(ALU_EN),    32'd0);
        chk("t1_busy",       32'(BUSY),      32'd1);
        chk("t1_no_valid",   32'(RES_VALID), 32'd0);
        ALU_OUT_VALID = 1'b1;
        ALU_OUT       = 16'h0046;
        exp_q.push_back('{data: 16'h0046, err: 1'b0});
        tick();
        ALU_OUT_VALID = 1'b0;
        ALU_OUT       = 16'hDEAD;
        chk("t1_res_valid",  32'(RES_VALID), 32'd1);
        chk("t1_res_data",   32'(RES_DATA),  32'h0046);
        chk("t1_res_err",    32'(RES_ERR),   32'd0);
        drive_cmd(8'hFF, 8'hEE, 4'hF);
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("hold_res_data",  32'(RES_DATA),  32'h0046);
            chk("hold_res_valid", 32'(RES_VALID), 32'd1);
            chk("hold_cmd_ready", 32'(CMD_READY), 32'd0);
            chk("hold_alu_a",     32'(ALU_A),     32'h12);
        end
        CMD_VALID = 1'b0;
        RES_READY = 1'b1;
        tick();
        chk("rel_cmd_ready", 32'(CMD_READY), 32'd1);
        chk("rel_res_valid", 32'(RES_VALID), 32'd0);
        chk("rel_alu_a",     32'(ALU_A),     32'h12);

        // Back-to-back commands with CMD_VALID held high.
        drive_cmd(8'h01, 8'h02, 4'b0110);
        tick();
        chk("b2b_fun1",      32'(ALU_FUN),   32'h6);
        chk("b2b_en1",       32'(ALU_EN),    32'd1);
        drive_cmd(8'h05, 8'h03, 4'b1101);
        tick();
        chk("b2b_ready_n2",  32'(CMD_READY), 32'd0);
        ALU_OUT_VALID = 1'b1;
        ALU_OUT       = 16'h0003;
        exp_q.push_back('{data: 16'h0003, err: 1'b0});
        tick();
        ALU_OUT_VALID = 1'b0;
        chk("b2b_valid1",    32'(RES_VALID), 32'd1);
        chk("b2b_ready_n3",  32'(CMD_READY), 32'd0);
        tick();
        chk("b2b_ready_n4",  32'(CMD_READY), 32'd1);
        chk("b2b_fun_hold",  32'(ALU_FUN),   32'h6);
        tick();
        CMD_VALID = 1'b0;
        chk("b2b_fun2",      32'(ALU_FUN),   32'hD);
        chk("b2b_en2",       32'(ALU_EN),    32'd1);
        chk("b2b_a2",        32'(ALU_A),     32'h05);
        tick();
        ALU_OUT_VALID = 1'b1;
        ALU_OUT       = 16'h0028;
        exp_q.push_back('{data: 16'h0028, err: 1'b0});
        tick();
        ALU_OUT_VALID = 1'b0;
        chk("b2b_valid2",    32'(RES_VALID), 32'd1);
        tick();
        chk("b2b_idle",      32'(CMD_READY), 32'd1);

`ifdef ALU_SEQ_TIMEOUT_EN
        // No strobe: error result after 15 WAIT cycles.
        drive_cmd(8'h11, 8'h22, 4'b1000);
        exp_q.push_back('{data: 16'h0000, err: 1'b1});
        for (int i = 1; i <= 16; i++) begin
            tick();
            CMD_VALID = 1'b0;
            chk("to_no_valid", 32'(RES_VALID), 32'd0);
        end
        tick();
        chk("to_valid",    32'(RES_VALID), 32'd1);
        chk("to_err",      32'(RES_ERR),   32'd1);
        chk("to_data",     32'(RES_DATA),  32'd0);
        tick();
        chk("to_idle",     32'(CMD_READY), 32'd1);

        // Strobe in the 15th WAIT cycle beats the timeout.
        drive_cmd(8'h11, 8'h22, 4'b1000);
        for (int i = 1; i <= 15; i++) begin
            tick();
            CMD_VALID = 1'b0;
            chk("tw_no_valid", 32'(RES_VALID), 32'd0);
        end
        tick();
        ALU_OUT_VALID = 1'b1;
        ALU_OUT       = 16'h00AA;
        exp_q.push_back('{data: 16'h00AA, err: 1'b0});
        tick();
        ALU_OUT_VALID = 1'b0;
        chk("tw_valid",    32'(RES_VALID), 32'd1);
        chk("tw_err",      32'(RES_ERR),   32'd0);
        tick();
`else
        // Without the timeout, WAIT persists until the strobe.
        drive_cmd(8'h11, 8'h22, 4'b1000);
        for (int i = 1; i <= 30; i++) begin
            tick();
            CMD_VALID = 1'b0;
            chk("nt_no_valid", 32'(RES_VALID), 32'd0);
        end
        ALU_OUT_VALID = 1'b1;
        ALU_OUT       = 16'h00AA;
        exp_q.push_back('{data: 16'h00AA, err: 1'b0});
        tick();
        ALU_OUT_VALID = 1'b0;
        chk("nt_valid",    32'(RES_VALID), 32'd1);
        chk("nt_err",      32'(RES_ERR),   32'd0);
        tick();
`endif

        // Reset asserted during WAIT.
        drive_cmd(8'h77, 8'h66, 4'b0101);
        tick();
        CMD_VALID = 1'b0;
        tick();
        chk("mr_busy_pre", 32'(BUSY), 32'd1);
        RST = 1'b0;
        #1;
        chk("mr_busy",      32'(BUSY),      32'd0);
        chk("mr_alu_en",    32'(ALU_EN),    32'd0);
        chk("mr_res_valid", 32'(RES_VALID), 32'd0);
        chk("mr_cmd_ready", 32'(CMD_READY), 32'd0);
        chk("mr_alu_a",     32'(ALU_A),     32'd0);
        tick();
        RST = 1'b1;
        tick();
        chk("mr_ready_after", 32'(CMD_READY), 32'd1);
        ALU_OUT_VALID = 1'b1;
        ALU_OUT       = 16'h1234;
        tick();
        ALU_OUT_VALID = 1'b0;
        chk("late_strobe_valid", 32'(RES_VALID), 32'd0);
        chk("late_strobe_busy",  32'(BUSY),      32'd0);
        tick();
        chk("late_strobe_valid2", 32'(RES_VALID), 32'd0);
        chk("late_strobe_data",   32'(RES_DATA),  32'd0);

        tick();
        chk("queue_empty", 32'(exp_q.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
